banco_registradores_param: RTL

Parametrised successor to the single-cycle MIPS register bank, for the pipelined datapath.
- Generic width, depth and read-port count; synchronous active-high reset of all registers.
- Registered reads with write-to-read bypass.
- Per-register busy scoreboard that the issue stage uses to detect RAW hazards on in-flight writes.
- Sits between decode (reads, reserve) and writeback (write).

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_scoreboard.sv | 58 +++++
 rtl/banco_registradores_param.sv | 125 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised register bank.
// Used by banco_registradores_param and regfile_scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 32;
  localparam int ZERO_REG   = 0;

  // Widest register the parity helper accepts; narrower words are zero-extended.
  localparam int PAR_MAX_W  = 128;

  function automatic int addr_width(input int depth);
    int w;
    w = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << w) < depth) w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for the register bank: tracks in-flight destinations,
// resolves same-cycle write/reserve priority and flags reserves of busy regs.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = addr_width(DEF_DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_en_i,
  input  logic [ADDR_W-1:0] write_addr_i,
  input  logic              reserve_en_i,
  input  logic [ADDR_W-1:0] reserve_addr_i,
  output logic [DEPTH-1:0]  busy_vector_o,
  output logic [DEPTH-1:0]  busy_next_o,
  output logic              reserve_ready_o,
  output logic              reserve_err_o
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             err_q, err_d;
  logic             wr_fire, rsv_fire, wr_hits_rsv;

  assign wr_fire     = write_en_i && (write_addr_i != ZERO_ADDR);
  assign rsv_fire    = reserve_en_i && (reserve_addr_i != ZERO_ADDR);
  assign wr_hits_rsv = wr_fire && (write_addr_i == reserve_addr_i);

  // A write retiring the old producer lets a same-cycle reserve claim the
  // register for the new producer without raising an error.
  always_comb begin
    busy_d = busy_q;
    err_d  = 1'b0;
    if (wr_fire) busy_d[write_addr_i] = 1'b0;
    if (rsv_fire) begin
      if (!busy_q[reserve_addr_i] || wr_hits_rsv) busy_d[reserve_addr_i] = 1'b1;
      else                                        err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy_vector_o   = busy_q;
  assign busy_next_o     = busy_d;
  assign reserve_ready_o = (reserve_addr_i == ZERO_ADDR) || !busy_q[reserve_addr_i];
  assign reserve_err_o   = err_q;

endmodule

// File: rtl/banco_registradores_param.sv
// Parametrised register bank with registered, bypassed reads and busy scoreboard.
// Optional even-parity protection when REGFILE_PARITY_EN is defined.
module banco_registradores_param
  import regfile_pkg::*;
#(
  parameter int                 DATA_W      = DEF_DATA_W,
  parameter int                 DEPTH       = DEF_DEPTH,
  parameter int                 NUM_READ    = 2,
  parameter logic [DATA_W-1:0]  RESET_VALUE = '0,
  localparam int                ADDR_W      = addr_width(DEPTH)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_READ*ADDR_W-1:0]   read_addr,
  output logic [NUM_READ*DATA_W-1:0]   read_data,
  output logic [NUM_READ-1:0]          read_busy,
  input  logic                         write_en,
  input  logic [ADDR_W-1:0]            write_addr,
  input  logic [DATA_W-1:0]            write_data,
  input  logic                         reserve_en,
  input  logic [ADDR_W-1:0]            reserve_addr,
  output logic                         reserve_ready,
  output logic                         reserve_err,
  output logic [DEPTH-1:0]             busy_vector
`ifdef REGFILE_PARITY_EN
  ,
  output logic [NUM_READ-1:0]          parity_err
`endif
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_next;
  logic              wr_fire;

  assign wr_fire = write_en && (write_addr != ZERO_ADDR);

  // Register 0 is held at zero; writes to it are dropped by wr_fire.
  always_ff @(posedge clock) begin
    if (reset) begin
      regs_q[0] <= '0;
      for (int k = 1; k < DEPTH; k++) regs_q[k] <= RESET_VALUE;
    end else if (wr_fire) begin
      regs_q[write_addr] <= write_data;
    end
  end

`ifdef REGFILE_PARITY_EN
  logic par_q [DEPTH];

  function automatic logic data_parity(input logic [DATA_W-1:0] d);
    logic [PAR_MAX_W-1:0] ext;
    ext             = '0;
    ext[DATA_W-1:0] = d;
    return even_parity(ext);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      par_q[0] <= 1'b0;
      for (int k = 1; k < DEPTH; k++) par_q[k] <= data_parity(RESET_VALUE);
    end else if (wr_fire) begin
      par_q[write_addr] <= data_parity(write_data);
    end
  end
`endif

  regfile_scoreboard #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clock           (clock),
    .reset           (reset),
    .write_en_i      (write_en),
    .write_addr_i    (write_addr),
    .reserve_en_i    (reserve_en),
    .reserve_addr_i  (reserve_addr),
    .busy_vector_o   (busy_vector),
    .busy_next_o     (busy_next),
    .reserve_ready_o (reserve_ready),
    .reserve_err_o   (reserve_err)
  );

  for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              ra_zero, bypass;
    logic [DATA_W-1:0] rdata_d, rdata_q;
    logic              rbusy_q;

    assign ra      = read_addr[i*ADDR_W +: ADDR_W];
    assign ra_zero = (ra == ZERO_ADDR);
    assign bypass  = wr_fire && (write_addr == ra);

    always_comb begin
      rdata_d = regs_q[ra];
      if (ra_zero)     rdata_d = '0;
      else if (bypass) rdata_d = write_data;
    end

    // Busy is sampled after this edge's write/reserve updates.
    always_ff @(posedge clock) begin
      if (reset) begin
        rdata_q <= '0;
        rbusy_q <= 1'b0;
      end else begin
        rdata_q <= rdata_d;
        rbusy_q <= busy_next[ra];
      end
    end

    assign read_data[i*DATA_W +: DATA_W] = rdata_q;
    assign read_busy[i]                  = rbusy_q;

`ifdef REGFILE_PARITY_EN
    logic perr_q;
    always_ff @(posedge clock) begin
      if (reset) perr_q <= 1'b0;
      else       perr_q <= !ra_zero && !bypass && (data_parity(regs_q[ra]) != par_q[ra]);
    end
    assign parity_err[i] = perr_q;
`endif
  end

endmodule
